// File: rtl/ps2_scan_decoder_if.sv
// Byte-in / event-out bus of the PS/2 scan-code decoder, plus its status outputs.
interface ps2_scan_decoder_if #(
    parameter int unsigned DEPTH_LOG2 = 3
);
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic                rd_en;
    logic                ev_valid;
    logic [7:0]          ev_code;
    logic                ev_ext;
    logic                ev_break;
    logic                ev_repeat;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                overflow;
    logic [7:0]          press_count;
    logic                held_valid;
    logic [7:0]          held_code;
    logic                held_ext;

    modport master (
        output byte_valid, byte_data, rd_en,
        input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
        input  fifo_level, overflow, press_count, held_valid, held_code, held_ext
    );

    modport slave (
        input  byte_valid, byte_data, rd_en,
        output ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
        output fifo_level, overflow, press_count, held_valid, held_code, held_ext
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Turns PS/2 scan bytes into make/break/repeat key events queued in a show-ahead FIFO.
// Also tracks the held key and a wrapping count of new key presses.
module ps2_scan_decoder #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic               clk,
    input  logic               clrn,
    ps2_scan_decoder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    // bit 0 = E0 seen, bit 1 = F0 seen
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EXT     = 2'b01,
        BRK     = 2'b10,
        EXT_BRK = 2'b11
    } state_t;

    typedef struct packed {
        logic       rpt;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    state_t                state;
    ev_t                   mem [DEPTH];
    ev_t                   head;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic [7:0]            press_count;
    logic                  held_valid;
    logic                  held_ext;
    logic [7:0]            held_code;

    logic                  ext_f;
    logic                  brk_f;
    logic                  is_discard;
    logic                  is_prefix;
    logic                  emit;
    logic                  held_match;
    logic                  is_repeat;
    logic                  full;
    logic                  pop;
    logic                  push;
    ev_t                   new_ev;
    ev_t                   head_n;
    logic [DEPTH_LOG2-1:0] rd_ptr_n;
    logic [LW-1:0]         level_n;

    // Byte classification, event formation and FIFO bookkeeping
    always_comb begin
        ext_f      = state[0];
        brk_f      = state[1];
        is_discard = 1'b0;
        case (bus.byte_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
            default:                                         is_discard = 1'b0;
        endcase
        is_prefix  = (bus.byte_data == 8'hE0) || (bus.byte_data == 8'hF0);
        emit       = bus.byte_valid && !is_prefix && !is_discard;
        held_match = held_valid && (held_ext == ext_f) && (held_code == bus.byte_data);
        is_repeat  = !brk_f && held_match;

        new_ev      = '0;
        new_ev.rpt  = is_repeat;
        new_ev.brk  = brk_f;
        new_ev.ext  = ext_f;
        new_ev.code = bus.byte_data;

        full     = (level == LW'(DEPTH));
        pop      = bus.rd_en && (level != '0);
        push     = emit && (!full || pop);
        rd_ptr_n = pop ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
        level_n  = level + LW'(push) - LW'(pop);

        // Registered head: the new entry lands at the head only when it is the sole entry
        if (level_n == '0)
            head_n = '0;
        else if (push && (level_n == LW'(1)))
            head_n = new_ev;
        else
            head_n = mem[rd_ptr_n];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            head        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            press_count <= '0;
            held_valid  <= 1'b0;
            held_ext    <= 1'b0;
            held_code   <= '0;
        end else begin
            if (bus.byte_valid) begin
                case (bus.byte_data)
                    8'hE0:   state <= brk_f ? EXT_BRK : EXT;
                    8'hF0:   state <= ext_f ? EXT_BRK : BRK;
                    default: state <= IDLE;
                endcase
            end

            // Held-key tracking applies whether or not the FIFO accepts the event
            if (emit) begin
                if (!brk_f) begin
                    if (!held_match) begin
                        press_count <= press_count + 8'd1;
                        held_valid  <= 1'b1;
                        held_ext    <= ext_f;
                        held_code   <= bus.byte_data;
                    end
                end else if (held_match) begin
                    held_valid <= 1'b0;
                end
            end

            if (emit && !push) overflow <= 1'b1;
            if (push)          wr_ptr   <= wr_ptr + DEPTH_LOG2'(1);
            rd_ptr <= rd_ptr_n;
            level  <= level_n;
            head   <= head_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_ev;
    end

    assign bus.ev_valid    = (level != '0);
    assign bus.ev_code     = head.code;
    assign bus.ev_ext      = head.ext;
    assign bus.ev_break    = head.brk;
    assign bus.ev_repeat   = head.rpt;
    assign bus.fifo_level  = level;
    assign bus.overflow    = overflow;
    assign bus.press_count = press_count;
    assign bus.held_valid  = held_valid;
    assign bus.held_code   = held_code;
    assign bus.held_ext    = held_ext;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder with a queue of expected events.
module tb_ps2_scan_decoder;
    localparam int unsigned DEPTH_LOG2 = 3;

    typedef struct packed {
        logic       rpt;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } exp_t;

    logic clk;
    logic clrn;
    int   checks;
    int   errors;
    exp_t sb[$];

    ps2_scan_decoder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

    ps2_scan_decoder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.rd_en      = 1'b0;
    endtask

    task automatic expect_ev(input logic rpt, input logic brk, input logic ext, input logic [7:0] code);
        exp_t e;
        e.rpt  = rpt;
        e.brk  = brk;
        e.ext  = ext;
        e.code = code;
        sb.push_back(e);
    endtask

    task automatic cmp_head(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(bus.ev_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed event code %0h expected no event", tag, bus.ev_code);
        end else begin
            e = sb.pop_front();
            chk({tag, "_code"},   32'(bus.ev_code),   32'(e.code));
            chk({tag, "_ext"},    32'(bus.ev_ext),    32'(e.ext));
            chk({tag, "_break"},  32'(bus.ev_break),  32'(e.brk));
            chk({tag, "_repeat"}, 32'(bus.ev_repeat), 32'(e.rpt));
        end
    endtask

    task automatic pop_check(input string tag);
        cmp_head(tag);
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_check(tag);
        chk({tag, "_empty"}, 32'(bus.ev_valid), 32'd0);
        chk({tag, "_level0"}, 32'(bus.fifo_level), 32'd0);
    endtask

    task automatic do_reset();
        sb.delete();
        clrn = 1'b0;
        #2;
        chk("rst_ev_valid",    32'(bus.ev_valid),    32'd0);
        chk("rst_ev_code",     32'(bus.ev_code),     32'd0);
        chk("rst_ev_flags",    32'({bus.ev_ext, bus.ev_break, bus.ev_repeat}), 32'd0);
        chk("rst_fifo_level",  32'(bus.fifo_level),  32'd0);
        chk("rst_overflow",    32'(bus.overflow),    32'd0);
        chk("rst_press_count", 32'(bus.press_count), 32'd0);
        chk("rst_held",        32'({bus.held_valid, bus.held_ext, bus.held_code}), 32'd0);
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        clrn           = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.rd_en      = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Make / break
        send(8'h1C); expect_ev(1'b0, 1'b0, 1'b0, 8'h1C);
        chk("mk_latency_valid", 32'(bus.ev_valid),    32'd1);
        chk("mk_press_count",   32'(bus.press_count), 32'd1);
        chk("mk_held_valid",    32'(bus.held_valid),  32'd1);
        chk("mk_held_code",     32'(bus.held_code),   32'h1C);
        send(8'hF0);
        send(8'h1C); expect_ev(1'b0, 1'b1, 1'b0, 8'h1C);
        chk("brk_held_valid",   32'(bus.held_valid),  32'd0);
        chk("brk_held_code",    32'(bus.held_code),   32'h1C);
        chk("brk_fifo_level",   32'(bus.fifo_level),  32'd2);
        drain("mkbrk");

        // Extended keys, both prefix orders
        send(8'hE0); send(8'h75); expect_ev(1'b0, 1'b0, 1'b1, 8'h75);
        chk("ext_held_ext", 32'(bus.held_ext), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75); expect_ev(1'b0, 1'b1, 1'b1, 8'h75);
        send(8'hF0); send(8'hE0); send(8'h75); expect_ev(1'b0, 1'b1, 1'b1, 8'h75);
        chk("ext_press_count", 32'(bus.press_count), 32'd2);
        drain("ext");

        // Discard bytes, then reset mid-sequence
        send(8'hAA); send(8'hFA);
        chk("disc_valid",       32'(bus.ev_valid),    32'd0);
        chk("disc_press_count", 32'(bus.press_count), 32'd2);
        send(8'hE0);
        do_reset();
        send(8'h75); expect_ev(1'b0, 1'b0, 1'b0, 8'h75);
        chk("rstmid_press_count", 32'(bus.press_count), 32'd1);
        drain("rstmid");

        // Typematic repeats
        do_reset();
        send(8'h1C); expect_ev(1'b0, 1'b0, 1'b0, 8'h1C);
        send(8'h1C); expect_ev(1'b1, 1'b0, 1'b0, 8'h1C);
        send(8'h1C); expect_ev(1'b1, 1'b0, 1'b0, 8'h1C);
        send(8'h23); expect_ev(1'b0, 1'b0, 1'b0, 8'h23);
        chk("typ_press_count", 32'(bus.press_count), 32'd2);
        chk("typ_held_code",   32'(bus.held_code),   32'h23);
        chk("typ_held_valid",  32'(bus.held_valid),  32'd1);
        drain("typ");

        // Overflow: nine back-to-back makes into a depth-8 FIFO
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(8'h10 + 8'(i));
            if (i < 8) expect_ev(1'b0, 1'b0, 1'b0, 8'h10 + 8'(i));
        end
        chk("ovf_level",       32'(bus.fifo_level),  32'd8);
        chk("ovf_flag",        32'(bus.overflow),    32'd1);
        chk("ovf_press_count", 32'(bus.press_count), 32'd9);
        cmp_head("ovf_head");
        bus.rd_en = 1'b1;
        send(8'h19); expect_ev(1'b0, 1'b0, 1'b0, 8'h19);
        chk("ovf_pushpop_level", 32'(bus.fifo_level), 32'd8);
        chk("ovf_sticky",        32'(bus.overflow),   32'd1);
        drain("ovf");
        chk("ovf_sticky_after_drain", 32'(bus.overflow), 32'd1);

        // Wrap: 256 alternating makes, each popped
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = (i % 2 == 1) ? 8'h33 : 8'h34;
            send(c); expect_ev(1'b0, 1'b0, 1'b0, c);
            if (i == 254) chk("wrap_press_ff", 32'(bus.press_count), 32'hFF);
            pop_check("wrap");
        end
        chk("wrap_press_00", 32'(bus.press_count), 32'd0);
        chk("wrap_level",    32'(bus.fifo_level),  32'd0);
        chk("wrap_valid",    32'(bus.ev_valid),    32'd0);
        chk("wrap_overflow", 32'(bus.overflow),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Consumes the byte stream from the PS/2 receiver and turns multi-byte scan-code sequences into key events. It handles the E0 extended prefix, the F0 break prefix, protocol/status bytes and typematic repeats. Decoded events go into a show-ahead FIFO, which is read by the display/CPU-side logic. The block also keeps a wrapping key-press counter and tracks the most recently held key.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 entries (8 by default).
- `clk`  in  1: system clock; all logic on its rising edge.
- `clrn`  in  1: asynchronous, active-low reset.
- `byte_valid`  in  1: one-cycle strobe; `byte_data` is a completed, parity-checked scan byte.
- `byte_data`  in  8: received scan byte.
- `rd_en`  in  1: pop the FIFO head; ignored when `ev_valid`=0.
- `ev_valid`  out  1: FIFO non-empty; the `ev_*` fields show the head entry.
- `ev_code`  out  8: scan code, excluding prefixes.
- `ev_ext`  out  1: the sequence carried the E0 prefix.
- `ev_break`  out  1: the sequence carried the F0 prefix (key release).
- `ev_repeat`  out  1: a make event for the currently held key (typematic).
- `fifo_level`  out  DEPTH_LOG2+1: number of stored entries.
- `overflow`  out  1: sticky; set when an event is dropped because the FIFO is full.
- `press_count`  out  8: count of new (non-repeat) make events; wraps 0xFF→0x00.
- `held_valid`  out  1: a key is currently held.
- `held_code`  out  8: code of the held key.
- `held_ext`  out  1: E0 flag of the held key.

## Operation
- Prefix flags `ext_f` and `brk_f` form a four-state FSM: IDLE (0,0), EXT (1,0), BRK (0,1), EXT_BRK (1,1).
- All transitions below occur only on `byte_valid`=1.
- **E0:** set `ext_f`. **F0:** set `brk_f`.
  - Flags accumulate, so E0 F0 and F0 E0 both reach EXT_BRK.
  - A repeated prefix leaves the state unchanged.
- **Discard bytes** 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF:
  - Return to IDLE.
  - No event, no counter change.
- **Any other byte** (code C):
  - Emit an event {repeat, brk_f, ext_f, C}.
  - Return to IDLE.
- **Make event** (`brk_f`=0):
  - If `held_valid` and {`held_ext`,`held_code`} == {`ext_f`,C}: repeat=1. `press_count` and held state are unchanged.
  - Otherwise: repeat=0, `press_count`+1, and the held state is loaded with {1, `ext_f`, C}.
- **Break event:**
  - repeat=0.
  - If {`ext_f`,C} matches the held key, clear `held_valid`. `held_code` and `held_ext` keep their last values.
  - A break for any other key leaves the held state unchanged.
  - A break event is still pushed to the FIFO.
- **FIFO:**
  - Circular buffer with DEPTH_LOG2-bit read/write pointers; pointers wrap naturally.
  - A full/empty tie is resolved by `fifo_level`.
- **Push when full:**
  - If `rd_en`=1 in the same cycle, the pop frees a slot and the push is accepted.
  - Otherwise the event is dropped and `overflow` is set to 1.
  - The FSM and counters still update as specified for a dropped event.
- **Pop when empty:** ignored. A simultaneous push into an empty FIFO is stored.
- `overflow` is cleared only by reset.

## Timing
- **Reset (`clrn`=0, asynchronous):**
  - All outputs are 0: `ev_valid`, `ev_*`, `fifo_level`, `overflow`, `press_count`, `held_*`.
  - FSM is in IDLE and both pointers are 0.
  - Reset mid-sequence (e.g. after E0) discards the partial prefix.
- **Latency:** `byte_valid` sampled high at edge N.
  - The FSM, counters and held state update at edge N.
  - The event is written at edge N.
  - `ev_valid`/`ev_*` are visible after edge N (a single-cycle path), provided the FIFO was empty.
- **Pop:** `rd_en`=1 with `ev_valid`=1 at edge N advances the head at edge N; the next entry, or `ev_valid`=0, appears after edge N.
- **Back-to-back input:** `byte_valid` may assert on consecutive cycles. Every byte is processed; there is no stall and no ready signal.
- `fifo_level` updates at the same edge as the push/pop: +1, −1, or unchanged for a simultaneous push and pop.

## Test plan
- **Make/break:** bytes 1C, F0 1C.
  - Event 1: code=1C, break=0, repeat=0; `press_count`=1 and `held_valid`=1 with `held_code`=1C.
  - Event 2: code=1C, break=1; `held_valid`=0.
  - `fifo_level` reaches 2.
- **Extended keys:** bytes E0 75, E0 F0 75.
  - Events: {ext=1, brk=0, 75} and {ext=1, brk=1, 75}.
  - Bytes F0 E0 75 produce the same break event.
- **Typematic:** bytes 1C 1C 1C, then 23.
  - Repeat flags are 0,1,1 for the three 1C events and 0 for 23.
  - Final `press_count`=2, `held_code`=23.
- **Discard/reset:**
  - Bytes AA, FA produce no events.
  - Byte E0, then `clrn` pulsed low, then 75: event ext=0 and all counters restarted from 0.
- **Overflow:** 9 distinct make codes with `rd_en`=0 and DEPTH_LOG2=3.
  - `fifo_level`=8 and `overflow`=1; the 9th event is lost.
  - A push with simultaneous pop while full is accepted and `fifo_level` stays 8.
  - Draining the FIFO returns the first 8 codes in order.
- **Wrap:** 256 alternating distinct make codes, each popped.
  - `press_count` wraps 0xFF→0x00.
  - The pointers wrap many times with no lost or duplicated entries.
